// File: rtl/mem_access_ctrl.sv
// MEM-stage front end: issues one load/store at a time on the data SRAM-like bus and hands results to WB.
// Optional build macro MEM_ADDR_CHECK_EN: misaligned lh/lhu/sh/lw/sw become AdEL/AdES with no bus request.
module mem_access_ctrl #(
   parameter int LOAD_OP_W  = 7,
   parameter int STORE_OP_W = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  es_valid,
   input  logic [LOAD_OP_W-1:0]  es_load_op,
   input  logic [STORE_OP_W-1:0] es_store_op,
   input  logic                  es_rf_wr,
   input  logic [31:0]           es_addr,
   input  logic [31:0]           es_wdata,
   output logic                  ms_allowin,
   output logic                  data_sram_req,
   output logic                  data_sram_wr,
   output logic [1:0]            data_sram_size,
   output logic [3:0]            data_sram_wstrb,
   output logic [31:0]           data_sram_addr,
   output logic [31:0]           data_sram_wdata,
   input  logic                  data_sram_addr_ok,
   input  logic                  data_sram_data_ok,
   input  logic [31:0]           data_sram_rdata,
   input  logic                  ws_allowin,
   input  logic                  flush,
   output logic                  ms_valid,
   output logic [LOAD_OP_W-1:0]  ms_load_op,
   output logic                  ms_rf_wr,
   output logic [31:0]           ms_addr,
   output logic [31:0]           ms_rdata,
   output logic                  ms_ex,
   output logic [4:0]            ms_excode
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic        discard_q, discard_d;
   logic        accept, go_bus, addr_err;
   logic        is_byte, is_half, is_word, is_part, is_store, is_mem;
   logic [1:0]  a;
   logic [1:0]  size_c;
   logic [3:0]  wstrb_c;
   logic [31:0] addr_c, wdata_c;
   logic        wr_q;
   logic [1:0]  size_q;
   logic [3:0]  wstrb_q;
   logic [31:0] bus_addr_q, bus_wdata_q;

   assign a        = es_addr[1:0];
   assign is_byte  = es_load_op[0] | es_load_op[1] | es_store_op[0];
   assign is_half  = es_load_op[2] | es_load_op[3] | es_store_op[1];
   assign is_word  = es_load_op[4] | es_store_op[2];
   assign is_part  = es_load_op[5] | es_load_op[6] | es_store_op[3] | es_store_op[4];
   assign is_store = |es_store_op;
   assign is_mem   = (|es_load_op) | is_store;

`ifdef MEM_ADDR_CHECK_EN
   assign addr_err = (is_half && es_addr[0]) || (is_word && (es_addr[1:0] != 2'b00));
`else
   assign addr_err = 1'b0;
`endif
   assign go_bus = is_mem && !addr_err;

   // Bus fields are computed from EX inputs and registered at accept so they stay stable through REQ.
   always_comb begin
      size_c  = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
      addr_c  = is_part ? {es_addr[31:2], 2'b00} : es_addr;
      wstrb_c = '0;
      wdata_c = es_wdata;
      if (es_store_op[0]) begin
         wstrb_c = 4'b0001 << a;
         wdata_c = {4{es_wdata[7:0]}};
      end else if (es_store_op[1]) begin
         wstrb_c = a[1] ? 4'b1100 : 4'b0011;
         wdata_c = {2{es_wdata[15:0]}};
      end else if (es_store_op[2]) begin
         wstrb_c = 4'b1111;
      end else if (es_store_op[3]) begin
         wstrb_c = 4'b1111 >> (2'd3 - a);
         wdata_c = es_wdata >> {(2'd3 - a), 3'b000};
      end else if (es_store_op[4]) begin
         wstrb_c = 4'b1111 << a;
         wdata_c = es_wdata << {a, 3'b000};
      end
   end

   assign ms_allowin = !discard_q && !flush && ((state_q == IDLE) || ((state_q == DONE) && ws_allowin));
   assign accept     = es_valid && ms_allowin;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
      end
   end

   // A flushed request is never withdrawn; discard swallows its response instead.
   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      case (state_q)
         IDLE: if (accept) state_d = go_bus ? REQ : DONE;
         REQ: begin
            if (flush) discard_d = 1'b1;
            if (data_sram_addr_ok) state_d = WAIT;
         end
         WAIT: begin
            if (flush) discard_d = 1'b1;
            if (data_sram_data_ok) begin
               state_d   = (discard_q || flush) ? IDLE : DONE;
               discard_d = 1'b0;
            end
         end
         DONE: begin
            if (flush)           state_d = IDLE;
            else if (accept)     state_d = go_bus ? REQ : DONE;
            else if (ws_allowin) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_sram_req = (state_q == REQ);
      ms_valid      = (state_q == DONE);
   end

   assign data_sram_wr    = wr_q;
   assign data_sram_size  = size_q;
   assign data_sram_wstrb = wstrb_q;
   assign data_sram_addr  = bus_addr_q;
   assign data_sram_wdata = bus_wdata_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_load_op  <= '0;
         ms_rf_wr    <= 1'b0;
         ms_addr     <= '0;
         ms_rdata    <= '0;
         wr_q        <= 1'b0;
         size_q      <= '0;
         wstrb_q     <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
      end else if (accept) begin
         ms_load_op  <= es_load_op;
         ms_rf_wr    <= es_rf_wr && !addr_err;
         ms_addr     <= es_addr;
         ms_rdata    <= '0;
         wr_q        <= is_store;
         size_q      <= size_c;
         wstrb_q     <= wstrb_c;
         bus_addr_q  <= addr_c;
         bus_wdata_q <= wdata_c;
      end else if ((state_q == WAIT) && data_sram_data_ok && !discard_q && !flush) begin
         ms_rdata <= data_sram_rdata;
      end
   end

`ifdef MEM_ADDR_CHECK_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_ex     <= 1'b0;
         ms_excode <= '0;
      end else if (accept) begin
         ms_ex     <= addr_err;
         ms_excode <= addr_err ? (is_store ? 5'h05 : 5'h04) : 5'h00;
      end
   end
`else
   assign ms_ex     = 1'b0;
   assign ms_excode = '0;
`endif

endmodule
